vedic_iter_mult: RTL and testbench

- Iterative WIDTH x WIDTH unsigned multiplier for the arithmetic-encoder datapath.
- Built as the sequential stage that drives a single vedic_2x2 cell.
- Each RUN cycle selects one 2-bit digit pair from the captured operands, feeds it to the 2x2 cell, and shift-accumulates the 4-bit partial product.
- Trades latency for area against a fully unrolled Vedic tree; valid/ready on both sides.

---
 rtl/vedic_pkg.sv | 13 +
 rtl/vedic_2x2.sv | 28 ++
 rtl/vedic_iter_mult.sv | 110 +++++++++++
 tb/tb_vedic_iter_mult.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vedic_pkg.sv
// Shared constants for the iterative Vedic multiplier: FSM state encoding
// and the width of one operand digit fed to the 2x2 cell.
package vedic_pkg;

    localparam int DIG_W = 2;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/vedic_2x2.sv
// 2-bit x 2-bit Vedic (Urdhva-Tiryagbhyam) multiplier cell, purely combinational.
module vedic_2x2
    import vedic_pkg::*;
(
    input  logic [DIG_W-1:0]   x,
    input  logic [DIG_W-1:0]   y,
    output logic [2*DIG_W-1:0] p
);

    logic vert_lo;
    logic cross_a;
    logic cross_b;
    logic vert_hi;
    logic carry_mid;

    assign vert_lo   = x[0] & y[0];
    assign cross_a   = x[1] & y[0];
    assign cross_b   = x[0] & y[1];
    assign vert_hi   = x[1] & y[1];
    // The crosswise sum can only carry when both cross terms are set.
    assign carry_mid = cross_a & cross_b;

    assign p[0] = vert_lo;
    assign p[1] = cross_a ^ cross_b;
    assign p[2] = vert_hi ^ carry_mid;
    assign p[3] = vert_hi & carry_mid;

endmodule

// File: rtl/vedic_iter_mult.sv
// Iterative WIDTH x WIDTH unsigned multiplier: one 2x2 Vedic cell is reused
// over all digit pairs, shift-accumulating partial products into a 2*WIDTH register.
module vedic_iter_mult
    import vedic_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int N_DIG = WIDTH / DIG_W;
    localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIG - 1);

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
            $error("vedic_iter_mult: WIDTH must be even and >= 4");
        end
    endgenerate

    state_t               state;
    logic [IDX_W-1:0]     i;
    logic [IDX_W-1:0]     j;
    logic [WIDTH-1:0]     a_r;
    logic [WIDTH-1:0]     b_r;
    logic [2*WIDTH-1:0]   acc;

    logic [DIG_W-1:0]     a_dig;
    logic [DIG_W-1:0]     b_dig;
    logic [2*DIG_W-1:0]   pp;
    logic [IDX_W:0]       dig_sum;
    logic [2*WIDTH-1:0]   pp_shifted;

    // Digit select: shifting by 2*index brings the wanted pair to the LSBs.
    assign a_dig = DIG_W'(a_r >> {i, 1'b0});
    assign b_dig = DIG_W'(b_r >> {j, 1'b0});

    vedic_2x2 u_cell (
        .x (a_dig),
        .y (b_dig),
        .p (pp)
    );

    assign dig_sum    = {1'b0, i} + {1'b0, j};
    assign pp_shifted = {{(2*WIDTH - 2*DIG_W){1'b0}}, pp} << {dig_sum, 1'b0};

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign product   = acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            i     <= '0;
            j     <= '0;
            a_r   <= '0;
            b_r   <= '0;
            acc   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r <= a;
                        b_r <= b;
                        acc <= '0;
                        i   <= '0;
                        j   <= '0;
                        // A zero operand makes the result known immediately.
                        if (a == '0 || b == '0) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    acc <= acc + pp_shifted;
                    if (j == LAST_IDX) begin
                        j <= '0;
                        if (i == LAST_IDX) begin
                            i     <= '0;
                            state <= ST_DONE;
                        end else begin
                            i <= i + IDX_W'(1);
                        end
                    end else begin
                        j <= j + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vedic_iter_mult.sv
// Bench for vedic_iter_mult: directed vectors, backpressure, reset abort,
// random back-to-back traffic against an a*b model, and exhaustive WIDTH=4.
module tb_vedic_iter_mult;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] product;

    logic        in_valid4 = 1'b0;
    logic        in_ready4;
    logic [3:0]  a4 = '0;
    logic [3:0]  b4 = '0;
    logic        out_valid4;
    logic [7:0]  product4;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vedic_iter_mult #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    vedic_iter_mult #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a4),
        .b         (b4),
        .out_valid (out_valid4),
        .out_ready (1'b1),
        .product   (product4)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    // Model: every accepted pair must come out as a*b, in order, after
    // 64 edges (0 when an operand is zero), held stable while out_valid.
    logic [31:0] exp_q[$];
    int          acc_edge = 0;
    int          exp_lat = 0;
    logic        was_valid = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            was_valid = 1'b0;
        end else begin
            chk("ready_valid_exclusive", {63'd0, out_valid & in_ready}, 64'd0);
            if (out_valid) begin
                if (!was_valid) chk("model_latency", 64'(cyc - acc_edge), 64'(exp_lat));
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", 64'd1, 64'd0);
                end else begin
                    chk("model_product", 64'(product), 64'(exp_q[0]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(32'(a) * 32'(b));
                acc_edge = cyc + 1;
                exp_lat  = (a == 16'd0 || b == 16'd0) ? 0 : 64;
            end
            was_valid = out_valid && !out_ready;
        end
    end

    task automatic run_op(input logic [15:0] x, input logic [15:0] y, input int stall,
                          output logic [31:0] res, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) chk("wait_in_ready_timeout", 64'd0, 64'd1);
        in_valid  = 1'b1;
        a         = x;
        b         = y;
        out_ready = (stall == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!out_valid) chk("wait_out_valid_timeout", 64'd0, 64'd1);
        lat = n;
        res = product;
        repeat (stall) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] res;
        int          lat;
        logic        seen;
        logic [15:0] rx;
        logic [15:0] ry;
        int          n;

        // Reset held for three cycles.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_product", 64'(product), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("idle_in_ready", {63'd0, in_ready}, 64'd1);
        chk("idle_out_valid", {63'd0, out_valid}, 64'd0);

        run_op(16'h1234, 16'h5678, 0, res, lat);
        chk("basic_product", 64'(res), 64'h0626_0060);
        chk("basic_latency", 64'(lat), 64'd64);
        chk("basic_in_ready_after", {63'd0, in_ready}, 64'd1);

        run_op(16'hFFFF, 16'hFFFF, 0, res, lat);
        chk("max_product", 64'(res), 64'hFFFE_0001);
        chk("max_latency", 64'(lat), 64'd64);

        run_op(16'h0000, 16'hBEEF, 0, res, lat);
        chk("zero_a_product", 64'(res), 64'd0);
        chk("zero_a_latency", 64'(lat), 64'd0);
        run_op(16'h0001, 16'h0000, 0, res, lat);
        chk("zero_b_product", 64'(res), 64'd0);
        chk("zero_b_latency", 64'(lat), 64'd0);

        run_op(16'h8000, 16'h0002, 0, res, lat);
        chk("top_bit_product", 64'(res), 64'h0001_0000);

        // Backpressure: result held, stray in_valid pulses ignored.
        in_valid  = 1'b1;
        a         = 16'h0003;
        b         = 16'h0003;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("bp_latency", 64'(n), 64'd64);
        for (int k = 0; k < 20; k++) begin
            in_valid = k[0];
            a        = 16'h00FF;
            b        = 16'h0011;
            @(posedge clk); #1;
            if (k % 5 == 4) begin
                chk("bp_product_hold", 64'(product), 64'h0000_0009);
                chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
                chk("bp_out_valid_high", {63'd0, out_valid}, 64'd1);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_out_valid", {63'd0, out_valid}, 64'd0);
        chk("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        chk("bp_single_handshake", {63'd0, out_valid}, 64'd0);

        // Reset asserted mid-computation aborts the operation.
        in_valid = 1'b1;
        a        = 16'h1234;
        b        = 16'h5678;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
        chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
        chk("abort_product", 64'(product), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_out_valid", {63'd0, seen}, 64'd0);
        chk("abort_idle_product", 64'(product), 64'd0);

        // Random back-to-back traffic with random stalls.
        for (int k = 0; k < 250; k++) begin
            rx = ($urandom_range(0, 15) == 0) ? 16'd0 : 16'($urandom);
            ry = ($urandom_range(0, 15) == 0) ? 16'd0 : 16'($urandom);
            run_op(rx, ry, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, res, lat);
            if (k < 4) chk("rand_product", 64'(res), 64'(32'(rx) * 32'(ry)));
        end
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        // WIDTH=4 instance, every operand pair.
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                n = 0;
                while (!in_ready4 && n < 20) begin
                    @(posedge clk); #1; n++;
                end
                in_valid4 = 1'b1;
                a4        = 4'(x);
                b4        = 4'(y);
                @(posedge clk); #1;
                in_valid4 = 1'b0;
                a4        = 4'($urandom);
                b4        = 4'($urandom);
                n = 0;
                while (!out_valid4 && n < 20) begin
                    @(posedge clk); #1; n++;
                end
                chk("w4_product", 64'(product4), 64'(x * y));
                chk("w4_latency", 64'(n), (x == 0 || y == 0) ? 64'd0 : 64'd4);
                chk("w4_exclusive", {63'd0, out_valid4 & in_ready4}, 64'd0);
                @(posedge clk); #1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
